// File: rtl/gcd_operand_sequencer.sv
// Feeds operand pairs into the shared-bus GCD core and returns its result over a
// valid/ready handshake, with a zero-operand bypass and a hung-run timeout.
module gcd_operand_sequencer #(
    parameter int W       = 16,
    parameter int LEAD    = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         gcd_start,
    output logic [W-1:0] gcd_data,
    input  logic         gcd_done,
    input  logic [W-1:0] gcd_result,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_result,
    output logic         out_timeout,
    output logic         busy
);

    localparam int LW = (LEAD > 1) ? $clog2(LEAD + 1) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        LOAD_A,
        LOAD_B,
        WAIT,
        DONE
    } state_t;

    state_t         state;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic [LW-1:0]  lead_cnt;
    logic [TW-1:0]  wait_cnt;
    logic [TW-1:0]  wait_next;

    always_comb begin
        wait_next = wait_cnt + TW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            op_a        <= '0;
            op_b        <= '0;
            lead_cnt    <= '0;
            wait_cnt    <= '0;
            in_ready    <= 1'b1;
            gcd_start   <= 1'b0;
            gcd_data    <= '0;
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_timeout <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        op_a     <= in_a;
                        op_b     <= in_b;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        // A zero operand would never terminate in the subtractive core.
                        if (in_a == '0 || in_b == '0) begin
                            state       <= DONE;
                            out_valid   <= 1'b1;
                            out_result  <= in_a | in_b;
                            out_timeout <= 1'b0;
                        end else begin
                            state     <= START;
                            gcd_start <= 1'b1;
                            gcd_data  <= '0;
                            lead_cnt  <= '0;
                        end
                    end
                end
                START: begin
                    if (lead_cnt == LW'(LEAD - 1)) begin
                        state    <= LOAD_A;
                        gcd_data <= op_a;
                    end else begin
                        lead_cnt <= lead_cnt + LW'(1);
                    end
                end
                LOAD_A: begin
                    state    <= LOAD_B;
                    gcd_data <= op_b;
                end
                LOAD_B: begin
                    state    <= WAIT;
                    wait_cnt <= '0;
                end
                WAIT: begin
                    // done wins over a timeout landing on the same cycle
                    if (gcd_done) begin
                        state       <= DONE;
                        gcd_start   <= 1'b0;
                        gcd_data    <= '0;
                        out_valid   <= 1'b1;
                        out_result  <= gcd_result;
                        out_timeout <= 1'b0;
                    end else if (wait_next == TW'(TIMEOUT)) begin
                        state       <= DONE;
                        gcd_start   <= 1'b0;
                        gcd_data    <= '0;
                        out_valid   <= 1'b1;
                        out_result  <= '0;
                        out_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_next;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        lead_cnt  <= '0;
                        wait_cnt  <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_operand_sequencer.sv
// Random and directed operand pairs against a behavioural GCD core and a
// reference model built from Euclid's algorithm and the handshake rules.
module tb_gcd_operand_sequencer;

    localparam int W       = 16;
    localparam int LEAD    = 2;
    localparam int TIMEOUT = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         gcd_start;
    logic [W-1:0] gcd_data;
    logic         gcd_done;
    logic [W-1:0] gcd_result;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         out_timeout;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    int last_hi = -100;

    logic [W-1:0] exp_a = '0;
    logic [W-1:0] exp_b = '0;
    int           core_delay = 1;
    bit           core_hang  = 1'b0;

    gcd_operand_sequencer #(.W(W), .LEAD(LEAD), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .gcd_start  (gcd_start),
        .gcd_data   (gcd_data),
        .gcd_done   (gcd_done),
        .gcd_result (gcd_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_timeout(out_timeout),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cycle++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Behavioural core: A arrives LEAD cycles after the start edge, B one cycle later,
    // done rises core_delay cycles after B and is left high until the next A.
    initial begin
        int           phase;
        logic         prev_start;
        logic [W-1:0] ca, cb;
        phase      = -1;
        prev_start = 1'b0;
        ca         = '0;
        cb         = '0;
        gcd_done   = 1'b0;
        gcd_result = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!gcd_start)      phase = -1;
            else if (!prev_start) phase = 0;
            else if (phase >= 0)  phase++;
            if (phase >= 0) begin
                if (phase < LEAD) begin
                    check("lead_data", gcd_data, 0);
                end else if (phase == LEAD) begin
                    check("data_a", gcd_data, exp_a);
                    ca       = gcd_data;
                    gcd_done = 1'b0;
                end else if (phase == LEAD + 1) begin
                    check("data_b", gcd_data, exp_b);
                    cb = gcd_data;
                end else begin
                    check("wait_data", gcd_data, exp_b);
                end
                if (!core_hang && phase == LEAD + 1 + core_delay) begin
                    gcd_done   = 1'b1;
                    gcd_result = gcd_ref(ca, cb);
                end
            end
            prev_start = gcd_start;
        end
    end

    task automatic wait_accept(output bit ok);
        int  n;
        bit  rdy;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 100) begin
            rdy = in_ready;
            @(posedge clk);
            #1;
            n++;
            if (rdy) ok = 1'b1;
        end
        check("accept", ok, 1);
        in_valid = 1'b0;
        in_a     = W'($urandom);
        in_b     = W'($urandom);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int d,
                          input int hold, input bit hang, input bit offer_extra);
        bit           zero, ok;
        logic [W-1:0] exp_res;
        bit           exp_to;
        int           starts, n;
        zero       = (a == 0) || (b == 0);
        exp_to     = !zero && hang;
        exp_res    = zero ? (a | b) : (hang ? '0 : gcd_ref(a, b));
        exp_a      = a;
        exp_b      = b;
        core_delay = d;
        core_hang  = hang;
        in_a       = a;
        in_b       = b;
        in_valid   = 1'b1;
        out_ready  = (hold == 0);
        wait_accept(ok);
        if (zero) begin
            check("bypass_latency", out_valid, 1);
        end else begin
            check("start_gap", (cycle - last_hi) >= 3, 1);
        end
        starts = 0;
        n      = 0;
        while (!out_valid && n < 200) begin
            check("busy_run", busy, 1);
            if (gcd_start) begin
                starts++;
                last_hi = cycle;
            end
            @(posedge clk);
            #1;
            n++;
        end
        check("out_valid", out_valid, 1);
        check("out_result", out_result, exp_res);
        check("out_timeout", out_timeout, exp_to);
        check("start_cycles", starts, zero ? 0 : LEAD + 2 + (hang ? TIMEOUT : d));
        check("done_start_low", gcd_start, 0);
        check("done_data_zero", gcd_data, 0);
        check("done_in_ready", in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            if (offer_extra) begin
                in_valid = 1'b1;
                in_a     = 16'd99;
                in_b     = 16'd33;
            end
            @(posedge clk);
            #1;
            check("hold_valid", out_valid, 1);
            check("hold_result", out_result, exp_res);
            check("hold_timeout", out_timeout, exp_to);
            check("hold_in_ready", in_ready, 0);
            check("hold_busy", busy, 1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("ack_valid", out_valid, 0);
        check("ack_in_ready", in_ready, 1);
        check("ack_busy", busy, 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_start"}, gcd_start, 0);
        check({tag, "_data"}, gcd_data, 0);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_result"}, out_result, 0);
        check({tag, "_timeout"}, out_timeout, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        bit ok;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst_n = 1'b1;

        run_op(16'd56, 16'd98, 3, 0, 1'b0, 1'b0);
        run_op(16'd0, 16'd35, 1, 0, 1'b0, 1'b0);
        run_op(16'd0, 16'd0, 1, 0, 1'b0, 1'b0);
        run_op(16'd48, 16'd18, 2, 10, 1'b0, 1'b1);
        run_op(16'd99, 16'd33, 1, 0, 1'b0, 1'b0);
        run_op(16'd40, 16'd24, 1, 2, 1'b1, 1'b0);
        run_op(16'd45, 16'd27, TIMEOUT, 1, 1'b0, 1'b0);

        // Reset while waiting on the core.
        exp_a     = 16'd56;
        exp_b     = 16'd98;
        core_hang = 1'b1;
        in_a      = 16'd56;
        in_b      = 16'd98;
        in_valid  = 1'b1;
        wait_accept(ok);
        repeat (LEAD + 3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_reset_values("midrun_reset");
        last_hi = -100;
        run_op(16'd21, 16'd14, 2, 0, 1'b0, 1'b0);

        // Back-to-back runs with stale done carried into the second.
        run_op(16'd56, 16'd98, 2, 0, 1'b0, 1'b0);
        run_op(16'd17, 16'd5, 4, 0, 1'b0, 1'b0);

        for (int k = 0; k < 30; k++) begin
            logic [W-1:0] a, b;
            a = W'($urandom_range(1, 60) * $urandom_range(1, 40));
            b = W'($urandom_range(1, 60) * $urandom_range(1, 40));
            if ($urandom_range(0, 7) == 0) a = '0;
            if ($urandom_range(0, 7) == 0) b = '0;
            run_op(a, b, $urandom_range(1, TIMEOUT), $urandom_range(0, 3),
                   $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
